// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, falling-edge start detection,
// mid-bit sampling with a baud down-counter, and a sticky ready/framing-error pair.
module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

    typedef enum logic {
        IDLE,
        RCV
    } state_t;

    state_t        state_reg, state_next;
    logic          sync1_reg, sync2_reg, prev_reg;
    logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
    logic [3:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    rx_data_reg, rx_data_next;
    logic          rdy_reg, rdy_next;
    logic          frm_err_reg, frm_err_next;

    logic          fall;
    logic          tick;

    assign fall = prev_reg & ~sync2_reg;
    // The sample fires on the cycle the count runs out, so a load of N
    // places the sample exactly N cycles after the load.
    assign tick = (baud_cnt_reg == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            prev_reg     <= 1'b1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            rx_data_reg  <= '0;
            rdy_reg      <= 1'b0;
            frm_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sync1_reg    <= RX;
            sync2_reg    <= sync1_reg;
            prev_reg     <= sync2_reg;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            rx_data_reg  <= rx_data_next;
            rdy_reg      <= rdy_next;
            frm_err_reg  <= frm_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        rx_data_next  = rx_data_reg;
        rdy_next      = rdy_reg;
        frm_err_next  = frm_err_reg;

        if (clr_rdy) begin
            rdy_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next    = RCV;
                    baud_cnt_next = HALF;
                    bit_cnt_next  = '0;
                    rdy_next      = 1'b0;
                    frm_err_next  = 1'b0;
                end
            end
            RCV: begin
                if (tick) begin
                    baud_cnt_next = FULL;
                    if (bit_cnt_reg == 4'd0) begin
                        // A high start sample means the edge was a glitch.
                        if (sync2_reg) begin
                            state_next = IDLE;
                        end else begin
                            bit_cnt_next = 4'd1;
                        end
                    end else if (bit_cnt_reg <= 4'd8) begin
                        shift_next   = {sync2_reg, shift_reg[7:1]};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else begin
                        // Completion overrides a coincident clr_rdy.
                        rx_data_next = shift_reg;
                        rdy_next     = 1'b1;
                        frm_err_next = ~sync2_reg;
                        state_next   = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_data = rx_data_reg;
    assign rdy     = rdy_reg;
    assign frm_err = frm_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one full-rate instance for exact latency and
// glitch rejection, one BAUD_DIV=16 instance for the remaining scenarios.
module tb_uart_rx;

    localparam int D_A = 2604;
    localparam int D_B = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       clr_a = 1'b0;
    logic       clr_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       rdy_a, rdy_b;
    logic       ferr_a, ferr_b;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx #(.BAUD_DIV(D_A)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx_a),
        .clr_rdy (clr_a),
        .rx_data (data_a),
        .rdy     (rdy_a),
        .frm_err (ferr_a)
    );

    uart_rx #(.BAUD_DIV(D_B)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx_b),
        .clr_rdy (clr_b),
        .rx_data (data_b),
        .rdy     (rdy_b),
        .frm_err (ferr_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; RX is left at the stop level.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic stop);
        int         len;
        logic [9:0] bits;
        len  = (sel == 0) ? D_A : D_B;
        bits = {stop, d, 1'b0};
        $display("frame: dut=%0d data=0x%02h stop=%0b", sel, d, stop);
        for (int i = 0; i < 10; i++) begin
            set_rx(sel, bits[i]);
            tick(len);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        #2;
        check("rst_data_a", data_a, 0);
        check("rst_rdy_a", rdy_a, 0);
        check("rst_ferr_a", ferr_a, 0);
        check("rst_data_b", data_b, 0);
        check("rst_rdy_b", rdy_b, 0);
        check("rst_ferr_b", ferr_b, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(4);

        // Two synchronizer edges put T0 on the 3rd edge after the fall;
        // rdy is visible after edge 3 + 1302 + 9*2604 = 24741.
        lat = 0;
        fork
            send_frame(0, 8'hA5, 1'b1);
            begin
                for (int n = 1; n <= 30000; n++) begin
                    @(posedge clk);
                    #1;
                    if (rdy_a) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        check("a5_latency", lat, 24741);
        check("a5_data", data_a, 8'hA5);
        check("a5_rdy", rdy_a, 1);
        check("a5_ferr", ferr_a, 0);

        set_rx(0, 1'b0);
        tick(500);
        set_rx(0, 1'b1);
        tick(3000);
        $display("glitch: dut=0 500 clocks low");
        check("glitch_rdy", rdy_a, 0);
        check("glitch_data", data_a, 8'hA5);
        check("glitch_ferr", ferr_a, 0);
        send_frame(0, 8'h3C, 1'b1);
        check("3c_data", data_a, 8'h3C);
        check("3c_rdy", rdy_a, 1);
        check("3c_ferr", ferr_a, 0);

        send_frame(1, 8'hA5, 1'b1);
        check("b_a5_data", data_b, 8'hA5);
        check("b_a5_rdy", rdy_b, 1);
        check("b_a5_ferr", ferr_b, 0);
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
        check("clr_rdy", rdy_b, 0);
        check("clr_data", data_b, 8'hA5);
        check("clr_ferr", ferr_b, 0);
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
        check("clr_idle_rdy", rdy_b, 0);
        check("clr_idle_data", data_b, 8'hA5);

        // Stop sample lands on edge 3 + 8 + 9*16 = 155.
        fork
            send_frame(1, 8'hC3, 1'b1);
            begin
                tick(154);
                clr_b = 1'b1;
                tick(1);
                clr_b = 1'b0;
            end
        join
        check("clr_coinc_rdy", rdy_b, 1);
        check("clr_coinc_data", data_b, 8'hC3);

        send_frame(1, 8'h55, 1'b1);
        check("b2b_55_data", data_b, 8'h55);
        check("b2b_55_rdy", rdy_b, 1);
        fork
            send_frame(1, 8'hFF, 1'b1);
            begin
                tick(2);
                check("b2b_pre_t0_rdy", rdy_b, 1);
                tick(1);
                check("b2b_t0_rdy", rdy_b, 0);
                tick(60);
                check("b2b_mid_data", data_b, 8'h55);
            end
        join
        check("b2b_ff_data", data_b, 8'hFF);
        check("b2b_ff_rdy", rdy_b, 1);
        check("b2b_ff_ferr", ferr_b, 0);

        fork
            send_frame(1, 8'h81, 1'b1);
            begin
                tick(16 * 5 + 5);
                rst_n = 1'b0;
                #1;
                $display("reset: asserted during data bit 4");
                check("rst_mid_data", data_b, 0);
                check("rst_mid_rdy", rdy_b, 0);
                check("rst_mid_ferr", ferr_b, 0);
            end
        join
        check("rst_hold_rdy", rdy_b, 0);
        rst_n = 1'b1;
        tick(4);
        send_frame(1, 8'h7E, 1'b1);
        check("7e_data", data_b, 8'h7E);
        check("7e_rdy", rdy_b, 1);
        check("7e_ferr", ferr_b, 0);

        send_frame(1, 8'h00, 1'b0);
        check("brk_data", data_b, 8'h00);
        check("brk_rdy", rdy_b, 1);
        check("brk_ferr", ferr_b, 1);
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
        tick(32);
        set_rx(1, 1'b1);
        tick(200);
        check("brk_no_restart_rdy", rdy_b, 0);
        check("brk_no_restart_ferr", ferr_b, 1);
        send_frame(1, 8'h96, 1'b1);
        check("96_data", data_b, 8'h96);
        check("96_rdy", rdy_b, 1);
        check("96_ferr", ferr_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: BAUD_DIV, 2604, clocks per bit period (12-bit range, even, >= 16).
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: RX  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-005 SHALL have port: clr_rdy  input  1  single-cycle strobe; consumer acknowledges rx_data.
REQ-006 SHALL have port: rx_data  output  8  last completed received byte.
REQ-007 SHALL have port: rdy  output  1  high when rx_data holds an unacknowledged byte.
REQ-008 SHALL have port: frm_err  output  1  high when the last completed frame had stop bit = 0.
REQ-009 SHALL use one clock only; reset is asynchronous and active-low.

Function
REQ-010 SHALL pass RX through two flops, both preset to 1, before any use.
REQ-011 SHALL keep a third flop, preset to 1, holding the previous synchronized RX value.
REQ-012 SHALL implement two states: IDLE and RCV.
REQ-013 IDLE -> RCV SHALL occur only on a synchronized falling edge (previous = 1, current = 0); this cycle is T0.
REQ-014 At T0 SHALL load the baud down-counter with BAUD_DIV/2, clear the bit counter, and clear rdy and frm_err.
REQ-015 In RCV the baud counter SHALL decrement each cycle; at 0 it SHALL take a sample and reload BAUD_DIV.
REQ-016 Sample k (k = 0..9) SHALL occur in cycle T0 + BAUD_DIV/2 + k*BAUD_DIV.
REQ-017 Sample 0 is the start bit; if it reads 1, SHALL return to IDLE with no rdy, no frm_err, and rx_data unchanged.
REQ-018 Samples 1..8 SHALL shift into an internal register LSB first; rx_data SHALL NOT change during RCV.
REQ-019 Sample 9 is the stop bit; at that edge SHALL copy the shift register to rx_data, set rdy, set frm_err = ~stop, and go to IDLE.
REQ-020 rdy SHALL first read high at T0 + BAUD_DIV/2 + 9*BAUD_DIV + 1.
REQ-021 rdy SHALL clear on clr_rdy or at the next T0, whichever comes first.
REQ-022 If clr_rdy coincides with frame completion, completion SHALL win: rdy = 1.
REQ-023 clr_rdy SHALL NOT affect rx_data or frm_err; clr_rdy while not rdy SHALL be ignored.
REQ-024 An overrun (new frame while rdy = 1) SHALL overwrite rx_data with no separate error flag.
REQ-025 After a frame with stop = 0 and RX still low, SHALL NOT start again until RX returns high and falls again.
REQ-026 A new start edge arriving in the same cycle the stop is sampled SHALL be detected on the following cycle.
REQ-027 RX transitions in RCV SHALL be ignored except at sample points.
REQ-028 Counter widths SHALL hold BAUD_DIV without overflow; the bit counter SHALL be 4 bits and never pass 9.

Reset
REQ-029 On rst_n low, immediately and regardless of state: state = IDLE, rx_data = 0x00, rdy = 0, frm_err = 0, sync and edge flops = 1, counters = 0.
REQ-030 Reset mid-frame SHALL abandon the frame; the first falling edge after release SHALL start a fresh frame.

Verification
REQ-031 Frame 0xA5 with stop = 1 -> rx_data = 0xA5, rdy = 1, frm_err = 0; rdy first high exactly 24739 cycles after T0 (BAUD_DIV = 2604).
REQ-032 Pulse clr_rdy one cycle after rdy -> rdy = 0 next cycle; rx_data stays 0xA5; repeat with clr_rdy at the completion edge -> rdy = 1.
REQ-033 RX low glitch of 500 clocks, then valid 0x3C -> no rdy from the glitch, state back in IDLE; 0x3C received with frm_err = 0.
REQ-034 Frame 0x00 with stop = 0, RX held low 3 bit times, then high -> rdy = 1, frm_err = 1, rx_data = 0x00; no further rdy until the next real frame.
REQ-035 Back-to-back 0x55 then 0xFF with no idle gap, no clr_rdy -> rdy drops at the second T0; rdy ends high with rx_data = 0xFF.
REQ-036 rst_n low at bit 4 of a 0x81 frame -> outputs zero at once; a following 0x7E frame is received correctly.
